instruction_fetch_stage: RTL and testbench
==========================================

Name: instruction_fetch_stage

Overview:
- IF stage of the RV32I pipeline, directly upstream of the instruction memory.
- Owns the program counter and drives the memory's combinational read address.
- Registers the returned instruction, with its PC and PC+4, into the IF/ID pipeline register.
- Handles hazard-unit stalls and EX-stage redirects (branch or jump) with flush.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSN, 32'h0000_0013, bubble encoding (addi x0,x0,0) inserted on flush.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- stall_if  input  1  hold PC and IF/ID contents this cycle.
- flush_id  input  1  replace IF/ID contents with a bubble.
- redirect_valid  input  1  take redirect_target as the next PC.
- redirect_target  input  XLEN  branch or jump target from EX.
- imem_addr  output  XLEN  byte address to instruction memory; equals the current PC.
- imem_rdata  input  32  little-endian instruction word returned combinationally by memory.
- ifid_pc  output  XLEN  PC of the instruction held in IF/ID.
- ifid_pc_plus4  output  XLEN  ifid_pc + 4.
- ifid_instr  output  32  instruction held in IF/ID.
- ifid_valid  output  1  IF/ID holds a real, non-bubble instruction.
- misaligned_fetch  output  1  sticky flag: a redirect target had bits[1:0] != 0.

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high; all state clears immediately when reset asserts, independent of clk.
- Reset values:
  - pc = RESET_PC
  - ifid_pc = 0, ifid_pc_plus4 = 0
  - ifid_instr = NOP_INSN, ifid_valid = 0
  - misaligned_fetch = 0
- First fetch: on the first rising edge after reset deasserts, IF/ID captures the instruction at RESET_PC with ifid_valid = 1, provided no stall or flush is asserted.
- Address path: imem_addr = pc, purely combinational. No other logic sits between pc and imem_addr.
- Latency: the instruction at PC p appears on ifid_* exactly one cycle after pc == p, unless it is stalled or flushed.
- Next-PC priority, evaluated each rising edge:
  1. redirect_valid: pc <= {redirect_target[XLEN-1:2], 2'b00}. Redirect wins over stall_if.
  2. stall_if: pc holds.
  3. Otherwise: pc <= pc + 4. Modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0.
- IF/ID update priority, evaluated each rising edge:
  1. flush_id or redirect_valid: ifid_instr <= NOP_INSN, ifid_valid <= 0, ifid_pc and ifid_pc_plus4 <= 0. The word fetched in a redirect cycle is wrong-path and is always discarded.
  2. stall_if: all ifid_* hold.
  3. Otherwise: ifid_pc <= pc, ifid_pc_plus4 <= pc + 4, ifid_instr <= imem_rdata, ifid_valid <= 1.
- Simultaneous events:
  - stall_if together with flush_id: flush wins for IF/ID; pc still holds.
  - stall_if together with redirect_valid: pc redirects and IF/ID flushes.
- Misalignment: misaligned_fetch sets on any redirect with redirect_target[1:0] != 0. It stays set until reset. The PC is still redirected to the word-aligned address.
- Reset mid-operation: an in-flight redirect or stall is discarded and the state returns to the reset values above.
- No internal FSM beyond the registers listed. The pc register is the only state ahead of IF/ID.

Decomposition:
- XLEN, RESET_PC and NOP_INSN go in RISCV_PKG.vh as macros, alongside INSTRUCTION_SIZE and MEM_SIZE.
- One sub-module, pc_register: the PC flop plus next-PC priority mux and alignment masking. It outputs pc and the redirect-taken indication.
- The IF/ID register stays in the top-level instruction_fetch_stage.

Test Plan:
- Reset then free-run 4 cycles with memory preloaded (0x0: 0x00500093, 0x4: 0x00A00113) -> ifid_pc sequence 0x0, 0x4, 0x8; ifid_instr 0x00500093 then 0x00A00113; ifid_valid 1 from the first edge.
- Assert stall_if for 2 cycles while pc = 0x8 -> pc stays 0x8 and ifid_* hold the 0x4 contents; after release ifid_pc = 0x8 on the next edge.
- redirect_valid with target 0x40 while pc = 0xC -> next cycle pc = 0x40 and ifid_valid = 0 with ifid_instr = 0x00000013; the cycle after, ifid_pc = 0x40 with valid = 1.
- redirect_valid, stall_if and flush_id asserted together with target 0x20 -> pc = 0x20, IF/ID bubble; misaligned_fetch stays 0.
- Redirect target 0x22 -> pc = 0x20, misaligned_fetch = 1 and stays 1 across later normal redirects; clears only on reset.
- Force pc to 0xFFFFFFFC via redirect, then free-run -> pc wraps to 0x0 and ifid_pc_plus4 = 0x0 for the 0xFFFFFFFC entry. Also assert reset asynchronously mid-cycle -> outputs take reset values before the next clk edge.

Source files
------------

// File: rtl/instruction_fetch_stage_pkg.sv
// rtl/instruction_fetch_stage_pkg.sv - shared constants for the RV32I fetch stage
package instruction_fetch_stage_pkg;

  localparam int          XLEN             = 32;
  localparam logic [31:0] RESET_PC         = 32'h0000_0000;
  // addi x0,x0,0 used as the pipeline bubble
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;
  // byte stride between sequential instructions
  localparam int          INSTRUCTION_SIZE = 4;
  // instruction memory depth in 32-bit words
  localparam int          MEM_SIZE         = 1024;

endpackage

// File: rtl/instruction_fetch_stage_pc_register.sv
// rtl/instruction_fetch_stage_pc_register.sv - program counter with next-PC priority mux
module pc_register #(
  parameter int               XLEN     = instruction_fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0]  RESET_PC = instruction_fetch_stage_pkg::RESET_PC[XLEN-1:0]
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  output logic [XLEN-1:0] pc_o,
  output logic            redirect_taken_o
);

  import instruction_fetch_stage_pkg::*;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  // Redirect beats stall; targets are forced to word alignment; increment wraps naturally
  always_comb begin
    pc_d = pc_q;
    if (redirect_valid_i) begin
      pc_d = {redirect_target_i[XLEN-1:2], 2'b00};
    end else if (!stall_i) begin
      pc_d = pc_q + XLEN'(INSTRUCTION_SIZE);
    end
  end

  // PC flop, cleared asynchronously to the boot address
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o             = pc_q;
  assign redirect_taken_o = redirect_valid_i;

endmodule

// File: rtl/instruction_fetch_stage.sv
// rtl/instruction_fetch_stage.sv - IF stage: PC, instruction fetch and IF/ID register
module instruction_fetch_stage #(
  parameter int              XLEN     = instruction_fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = instruction_fetch_stage_pkg::RESET_PC[XLEN-1:0],
  parameter logic [31:0]     NOP_INSN = instruction_fetch_stage_pkg::NOP_INSN
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall_if,
  input  logic            flush_id,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] ifid_pc,
  output logic [XLEN-1:0] ifid_pc_plus4,
  output logic [31:0]     ifid_instr,
  output logic            ifid_valid,
  output logic            misaligned_fetch
);

  import instruction_fetch_stage_pkg::*;

  logic [XLEN-1:0] pc;
  logic            redirect_taken;

  logic [XLEN-1:0] ifid_pc_q;
  logic [XLEN-1:0] ifid_pc_plus4_q;
  logic [31:0]     ifid_instr_q;
  logic            ifid_valid_q;
  logic            misaligned_q;

  pc_register #(
    .XLEN     (XLEN),
    .RESET_PC (RESET_PC)
  ) u_pc_register (
    .clk               (clk),
    .reset             (reset),
    .stall_i           (stall_if),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .pc_o              (pc),
    .redirect_taken_o  (redirect_taken)
  );

  // Memory is read combinationally straight from the PC
  assign imem_addr = pc;

  // IF/ID register: flush or redirect inserts a bubble, stall holds, else capture the fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_instr_q    <= NOP_INSN;
      ifid_valid_q    <= 1'b0;
    end else if (flush_id || redirect_taken) begin
      ifid_pc_q       <= '0;
      ifid_pc_plus4_q <= '0;
      ifid_instr_q    <= NOP_INSN;
      ifid_valid_q    <= 1'b0;
    end else if (!stall_if) begin
      ifid_pc_q       <= pc;
      ifid_pc_plus4_q <= pc + XLEN'(INSTRUCTION_SIZE);
      ifid_instr_q    <= imem_rdata;
      ifid_valid_q    <= 1'b1;
    end
  end

  // Sticky misaligned-target flag, only reset clears it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      misaligned_q <= 1'b0;
    end else if (redirect_valid && (redirect_target[1:0] != 2'b00)) begin
      misaligned_q <= 1'b1;
    end
  end

  assign ifid_pc          = ifid_pc_q;
  assign ifid_pc_plus4    = ifid_pc_plus4_q;
  assign ifid_instr       = ifid_instr_q;
  assign ifid_valid       = ifid_valid_q;
  assign misaligned_fetch = misaligned_q;

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// tb/tb_instruction_fetch_stage.sv - directed self-checking bench for instruction_fetch_stage
module tb_instruction_fetch_stage;

  localparam int MEM_WORDS = 1024;
  localparam int AW        = $clog2(MEM_WORDS);

  logic        clk;
  logic        reset;
  logic        stall_if;
  logic        flush_id;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;
  logic [31:0] ifid_instr;
  logic        ifid_valid;
  logic        misaligned_fetch;

  logic [31:0] mem [MEM_WORDS];

  int checks;
  int errors;

  instruction_fetch_stage dut (
    .clk              (clk),
    .reset            (reset),
    .stall_if         (stall_if),
    .flush_id         (flush_id),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .ifid_pc          (ifid_pc),
    .ifid_pc_plus4    (ifid_pc_plus4),
    .ifid_instr       (ifid_instr),
    .ifid_valid       (ifid_valid),
    .misaligned_fetch (misaligned_fetch)
  );

  // combinational instruction memory; address wraps within the array
  assign imem_rdata = mem[imem_addr[AW+1:2]];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // advance one rising edge and settle away from it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] pc, input logic [31:0] instr,
                            input logic valid);
    check({tag, "_pc"}, ifid_pc, pc);
    check({tag, "_pc4"}, ifid_pc_plus4, valid ? pc + 32'd4 : 32'd0);
    check({tag, "_instr"}, ifid_instr, instr);
    check({tag, "_valid"}, {31'd0, ifid_valid}, {31'd0, valid});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < MEM_WORDS; i++) mem[i] = 32'hA000_0000 | i;
    mem[0] = 32'h0050_0093;
    mem[1] = 32'h00A0_0113;
    mem[2] = 32'h00F0_0193;
    mem[3] = 32'h0140_0213;

    reset = 1'b1;
    stall_if = 1'b0;
    flush_id = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = 32'd0;
    #2;
    check("rst_addr", imem_addr, 32'h0);
    check_ifid("rst", 32'h0, 32'h0000_0013, 1'b0);
    check("rst_mis", {31'd0, misaligned_fetch}, 32'd0);

    step();
    reset = 1'b0;

    // free run
    step();
    check_ifid("run0", 32'h0, 32'h0050_0093, 1'b1);
    check("run0_addr", imem_addr, 32'h4);
    step();
    check_ifid("run1", 32'h4, 32'h00A0_0113, 1'b1);
    check("run1_addr", imem_addr, 32'h8);

    // two stall cycles at pc 0x8
    stall_if = 1'b1;
    step();
    check_ifid("stall0", 32'h4, 32'h00A0_0113, 1'b1);
    check("stall0_addr", imem_addr, 32'h8);
    step();
    check_ifid("stall1", 32'h4, 32'h00A0_0113, 1'b1);
    check("stall1_addr", imem_addr, 32'h8);
    stall_if = 1'b0;
    step();
    check_ifid("rel", 32'h8, 32'h00F0_0193, 1'b1);
    check("rel_addr", imem_addr, 32'hC);

    // redirect to 0x40 from pc 0xC
    redirect_valid = 1'b1;
    redirect_target = 32'h40;
    step();
    redirect_valid = 1'b0;
    check("redir_addr", imem_addr, 32'h40);
    check_ifid("redir", 32'h0, 32'h0000_0013, 1'b0);
    step();
    check_ifid("redir_next", 32'h40, 32'hA000_0010, 1'b1);
    check("redir_next_addr", imem_addr, 32'h44);

    // redirect + stall + flush together
    redirect_valid = 1'b1;
    stall_if = 1'b1;
    flush_id = 1'b1;
    redirect_target = 32'h20;
    step();
    redirect_valid = 1'b0;
    stall_if = 1'b0;
    flush_id = 1'b0;
    check("all3_addr", imem_addr, 32'h20);
    check_ifid("all3", 32'h0, 32'h0000_0013, 1'b0);
    check("all3_mis", {31'd0, misaligned_fetch}, 32'd0);
    step();
    check_ifid("all3_next", 32'h20, 32'hA000_0008, 1'b1);

    // stall with flush: pc holds, IF/ID bubbles
    stall_if = 1'b1;
    flush_id = 1'b1;
    step();
    stall_if = 1'b0;
    flush_id = 1'b0;
    check("sf_addr", imem_addr, 32'h24);
    check_ifid("sf", 32'h0, 32'h0000_0013, 1'b0);
    step();
    check_ifid("sf_next", 32'h24, 32'hA000_0009, 1'b1);

    // misaligned target
    redirect_valid = 1'b1;
    redirect_target = 32'h22;
    step();
    check("mis_addr", imem_addr, 32'h20);
    check("mis_set", {31'd0, misaligned_fetch}, 32'd1);
    redirect_target = 32'h100;
    step();
    check("mis_addr2", imem_addr, 32'h100);
    check("mis_sticky", {31'd0, misaligned_fetch}, 32'd1);

    // wrap-around at top of address space
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wrap_addr1", imem_addr, 32'h0);
    check_ifid("wrap", 32'hFFFF_FFFC, 32'hA000_03FF, 1'b1);
    check("wrap_pc4", ifid_pc_plus4, 32'h0);
    check("wrap_mis", {31'd0, misaligned_fetch}, 32'd1);
    step();
    check_ifid("wrap_next", 32'h0, 32'h0050_0093, 1'b1);

    // asynchronous reset mid-cycle with a redirect and stall in flight
    redirect_valid = 1'b1;
    stall_if = 1'b1;
    redirect_target = 32'h80;
    #2;
    reset = 1'b1;
    #1;
    check("areset_addr", imem_addr, 32'h0);
    check_ifid("areset", 32'h0, 32'h0000_0013, 1'b0);
    check("areset_mis", {31'd0, misaligned_fetch}, 32'd0);
    redirect_valid = 1'b0;
    stall_if = 1'b0;
    step();
    check("areset_hold", imem_addr, 32'h0);
    reset = 1'b0;
    step();
    check_ifid("refetch", 32'h0, 32'h0050_0093, 1'b1);
    check("refetch_addr", imem_addr, 32'h4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
